// File: rtl/bias_accum_sat_stage.sv
// Per-lane bias add, multi-pass partial-sum accumulation and saturation, with a valid/ready output stage.
// Optional macro BIAS_ACCUM_RELU_EN clamps negative saturated lane results to zero.
module bias_accum_sat_stage #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DW           = 18,
  parameter int unsigned NUM_PASSES   = 4,
  parameter int unsigned GUARD        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_adder_tree*DW-1:0]   bias_q,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_adder_tree*DW-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_adder_tree*DW-1:0]   out_data,
  output logic [N_adder_tree-1:0]      out_sat,
  output logic [$clog2(NUM_PASSES):0]  pass_cnt
);

  localparam int unsigned AW = DW + GUARD;
  localparam int unsigned CW = $clog2(NUM_PASSES) + 1;
  localparam int unsigned VW = N_adder_tree * DW;

  typedef enum logic {ST_ACCUM, ST_OUTPUT} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          pass_cnt_q, pass_cnt_d;
  logic [AW-1:0]          acc_q [N_adder_tree];
  logic [AW-1:0]          acc_d [N_adder_tree];
  logic                   out_valid_q, out_valid_d;
  logic [VW-1:0]          out_data_q, out_data_d;
  logic [N_adder_tree-1:0] out_sat_q, out_sat_d;

  logic [AW-1:0]           sum_c [N_adder_tree];
  logic [VW-1:0]           res_c;
  logic [N_adder_tree-1:0] sat_c;
  logic                    accept;
  logic                    last_beat;

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (pass_cnt_q == CW'(NUM_PASSES - 1));

  // Per-lane sum, saturation to DW bits, optional ReLU
  for (genvar i = 0; i < int'(N_adder_tree); i++) begin : g_lane
    logic [DW-1:0] in_lane, b_lane, sat_val, res;
    logic [AW-1:0] in_ext, b_ext, sum;
    logic          ovf;

    assign in_lane = in_data[DW*i +: DW];
    assign b_lane  = bias_q[DW*i +: DW];
    assign in_ext  = {{GUARD{in_lane[DW-1]}}, in_lane};
    assign b_ext   = {{GUARD{b_lane[DW-1]}}, b_lane};
    assign sum     = (pass_cnt_q == '0) ? (b_ext + in_ext) : (acc_q[i] + in_ext);
    // Representable in DW bits only if all bits above the DW sign bit match it
    assign ovf     = (sum[AW-1:DW-1] != {(GUARD+1){sum[AW-1]}});
    assign sat_val = ovf ? (sum[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                         : sum[DW-1:0];
`ifdef BIAS_ACCUM_RELU_EN
    assign res     = sat_val[DW-1] ? '0 : sat_val;
`else
    assign res     = sat_val;
`endif
    assign sum_c[i]            = sum;
    assign res_c[DW*i +: DW]   = res;
    assign sat_c[i]            = ovf;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_ACCUM;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:  if (last_beat)                state_d = ST_OUTPUT;
      ST_OUTPUT: if (out_valid_q && out_ready) state_d = ST_ACCUM;
      default:                                 state_d = ST_ACCUM;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    in_ready    = rst_n && (state_q == ST_ACCUM);
    pass_cnt_d  = pass_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    for (int i = 0; i < int'(N_adder_tree); i++) acc_d[i] = acc_q[i];

    if (accept) begin
      for (int i = 0; i < int'(N_adder_tree); i++) acc_d[i] = sum_c[i];
      pass_cnt_d = last_beat ? '0 : pass_cnt_q + CW'(1);
    end
    if (last_beat) begin
      out_valid_d = 1'b1;
      out_data_d  = res_c;
      out_sat_d   = sat_c;
    end
    if ((state_q == ST_OUTPUT) && out_valid_q && out_ready) out_valid_d = 1'b0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      for (int i = 0; i < int'(N_adder_tree); i++) acc_q[i] <= '0;
    end else begin
      pass_cnt_q  <= pass_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      for (int i = 0; i < int'(N_adder_tree); i++) acc_q[i] <= acc_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_bias_accum_sat_stage.sv
// Directed and table-driven checks for bias_accum_sat_stage (default parameters).
module tb_bias_accum_sat_stage;

  localparam int NL = 16;
  localparam int DW = 18;
  localparam int VW = NL * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] bias_q;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [NL-1:0] out_sat;
  logic [2:0]    pass_cnt;

  int total = 0;
  int bad   = 0;
  int bias_v [NL];

  typedef struct {
    int   lane;
    int   beat;
    int   exp_val;
    logic exp_sat;
  } vec_t;
  vec_t tbl [8];

  bias_accum_sat_stage dut (
    .clk(clk), .rst_n(rst_n), .bias_q(bias_q),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef BIAS_ACCUM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Expected vector: target lane holds val, every other lane holds its own bias
  function automatic logic [VW-1:0] build_exp(input int lane, input int val);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < NL; j++)
      v[j*DW +: DW] = DW'(relu((j == lane) ? val : bias_v[j]));
    return v;
  endfunction

  function automatic logic [VW-1:0] one_lane(input int lane, input int val);
    logic [VW-1:0] v;
    v = '0;
    v[lane*DW +: DW] = DW'(val);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back beats of val on one lane; leaves the DUT presenting the result
  task automatic run_vector(input int lane, input int val, input string tag);
    for (int k = 0; k < 4; k++) begin
      in_data  = one_lane(lane, val);
      in_valid = 1'b1;
      tick();
      if (k < 3) begin
        chk({tag, "_mid_valid"}, VW'(out_valid), VW'(0));
        chk({tag, "_mid_cnt"}, VW'(pass_cnt), VW'(k + 1));
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk({tag, "_valid"}, VW'(out_valid), VW'(1));
    chk({tag, "_ready_low"}, VW'(in_ready), VW'(0));
    chk({tag, "_cnt0"}, VW'(pass_cnt), VW'(0));
  endtask

  initial begin
    logic [VW-1:0] held_data;
    logic [NL-1:0] held_sat;
    int            cnt;
    int            sum;
    int            d;
    logic          v;

    tbl[0] = '{0, 100,      1182,    1'b0};
    tbl[1] = '{1, 131071,   131071,  1'b1};
    tbl[2] = '{2, -131072,  -131072, 1'b1};
    tbl[3] = '{3, 0,        -1094,   1'b0};
    tbl[4] = '{4, -50000,   -131072, 1'b1};
    tbl[5] = '{5, 30000,    131071,  1'b0};
    tbl[6] = '{6, -32768,   -131072, 1'b0};
    tbl[7] = '{7, 32768,    131071,  1'b1};

    bias_v[0] = 782;  bias_v[1] = 1006; bias_v[2] = -364; bias_v[3] = -1094;
    bias_v[4] = 0;    bias_v[5] = 11071; bias_v[6] = 0;
    for (int j = 7; j < NL; j++) bias_v[j] = j * 100;
    bias_q = '0;
    for (int j = 0; j < NL; j++) bias_q[j*DW +: DW] = DW'(bias_v[j]);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_out_data", out_data, VW'(0));
    chk("rst_out_sat", VW'(out_sat), VW'(0));
    chk("rst_pass_cnt", VW'(pass_cnt), VW'(0));
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", VW'(in_ready), VW'(1));

    // Table: one lane driven, full-vector compare, single-cycle bubble
    for (int t = 0; t < 8; t++) begin
      run_vector(tbl[t].lane, tbl[t].beat, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d_data", t), out_data, build_exp(tbl[t].lane, tbl[t].exp_val));
      chk($sformatf("tbl%0d_sat", t), VW'(out_sat), VW'(NL'(tbl[t].exp_sat) << tbl[t].lane));
      tick();
      chk($sformatf("tbl%0d_drop", t), VW'(out_valid), VW'(0));
      chk($sformatf("tbl%0d_ready", t), VW'(in_ready), VW'(1));
    end

    // Output stall: held result, no beats taken, then exactly one handshake
    out_ready = 1'b0;
    run_vector(1, 131071, "stall");
    held_data = build_exp(1, 131071);
    held_sat  = NL'(2);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = one_lane(0, 5000 + c);
      tick();
      chk("stall_valid", VW'(out_valid), VW'(1));
      chk("stall_data", out_data, held_data);
      chk("stall_sat", VW'(out_sat), VW'(held_sat));
      chk("stall_ready", VW'(in_ready), VW'(0));
      chk("stall_cnt", VW'(pass_cnt), VW'(0));
    end
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    chk("stall_release", VW'(out_valid), VW'(0));
    tick();
    chk("stall_one_hs", VW'(out_valid), VW'(0));
    chk("stall_cnt_fresh", VW'(pass_cnt), VW'(0));
    run_vector(0, 10, "after_stall");
    chk("after_stall_data", out_data, build_exp(0, 822));
    tick();

    // Reset mid-accumulation discards the partial vector
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = one_lane(0, 5000);
      tick();
    end
    in_valid = 1'b0; in_data = '0;
    chk("mid_cnt2", VW'(pass_cnt), VW'(2));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", VW'(in_ready), VW'(0));
    chk("mid_rst_cnt", VW'(pass_cnt), VW'(0));
    chk("mid_rst_valid", VW'(out_valid), VW'(0));
    rst_n = 1'b1;
    run_vector(0, 10, "after_rst");
    chk("after_rst_data", out_data, build_exp(0, 822));
    chk("after_rst_sat", VW'(out_sat), VW'(0));
    tick();

    // Random 1-in-3 valid; beats during the output cycle must be ignored
    for (int vct = 0; vct < 3; vct++) begin
      cnt = 0; sum = 0;
      for (int cyc = 0; cyc < 300 && cnt < 4; cyc++) begin
        v = ($urandom_range(2) == 0);
        d = int'($urandom_range(2000)) - 1000;
        in_valid = v;
        in_data  = one_lane(0, d);
        tick();
        if (v) begin
          cnt++;
          sum += d;
        end
        if (cnt < 4) chk("rnd_mid_valid", VW'(out_valid), VW'(0));
      end
      if (cnt < 4) begin
        total++; bad++;
        $display("FAIL rnd_timeout: got %0d beats expected 4", cnt);
      end
      chk("rnd_valid", VW'(out_valid), VW'(1));
      chk("rnd_data", out_data, build_exp(0, 782 + sum));
      in_valid = 1'b1;
      in_data  = one_lane(0, 999);
      tick();
      chk("rnd_drop", VW'(out_valid), VW'(0));
      chk("rnd_cnt0", VW'(pass_cnt), VW'(0));
    end
    in_valid = 1'b0;
    in_data  = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
